// File: rtl/exec_pkg.sv
// Shared definitions for the execution units.
// Holds reservation-station entry field offsets, the divide opcode enum,
// the divide FSM state enum and the CDB tag width.
package exec_pkg;

   localparam int TAG_WIDTH = 6;
   localparam int XLEN      = 32;

   // Bit offsets (LSB positions) of fields inside a reservation-station entry.
   localparam int RS1_DATA = 52;   // [83:52]
   localparam int RS1_VLD  = 51;   // [51]
   localparam int RS1_TAG  = 45;   // [50:45]
   localparam int RS2_DATA = 13;   // [44:13]
   localparam int RS2_VLD  = 12;   // [12]
   localparam int RS2_TAG  = 6;    // [11:6]
   localparam int DEST_TAG = 0;    // [5:0]
   localparam int DIV_OP   = 84;   // [85:84]

   // Bit 1 selects remainder, bit 0 selects unsigned.
   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/exec_div_step.sv
// One restoring-division step, purely combinational.
// Ports:
//   i_rq      : current {remainder, quotient} shift register (64 bits)
//   i_divisor : unsigned divisor
//   o_rq      : {remainder, quotient} after one shift/subtract step
module exec_div_step (
   input  logic [63:0] i_rq,
   input  logic [31:0] i_divisor,
   output logic [63:0] o_rq
);

   logic [33:0] diff;

   // The shifted partial remainder can reach 33 bits when the divisor is
   // above 2^31, so the trial subtraction is carried out one bit wider.
   always_comb begin
      diff = {1'b0, i_rq[63:31]} - {2'b00, i_divisor};
      if (diff[33]) begin
         o_rq = {i_rq[62:0], 1'b0};
      end else begin
         o_rq = {diff[31:0], i_rq[30:0], 1'b1};
      end
   end

endmodule

// File: rtl/exec_div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit fed by the divide reservation station.
// Accepts one entry, iterates 32 restoring steps on operand magnitudes,
// applies the sign fix-up, then holds the result on a CDB request until granted.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_flush             : drops any in-flight operation
//   i_issue_valid/data  : ready entry from the station
//   o_issue_completed   : entry accepted this cycle
//   o_busy              : unit is in DIV or DONE
//   o_cdb_req           : result pending
//   i_cdb_grant         : CDB arbiter grant
//   o_cdb_valid/tag/data: broadcast of the result
//
// Handshake: an entry transfers in a cycle where the unit is IDLE, i_issue_valid
// is 1 and i_flush is 0; o_issue_completed marks that cycle. A result transfers
// in a cycle where o_cdb_req and i_cdb_grant are both 1 (and no flush/reset);
// o_cdb_valid marks that cycle, and tag/data are stable while o_cdb_req waits.
module exec_div_unit #(
   parameter int DATA_WIDTH = 128,
   parameter int TAG_WIDTH  = exec_pkg::TAG_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_flush,
   input  logic                  i_issue_valid,
   input  logic [DATA_WIDTH-1:0] i_issue_data,
   output logic                  o_issue_completed,
   output logic                  o_busy,
   output logic                  o_cdb_req,
   input  logic                  i_cdb_grant,
   output logic                  o_cdb_valid,
   output logic [TAG_WIDTH-1:0]  o_cdb_tag,
   output logic [31:0]           o_cdb_data
);

   import exec_pkg::*;

   div_state_t           state_q, state_d;
   logic [5:0]           cnt_q, cnt_d;
   logic [63:0]          rq_q, rq_d;
   logic [31:0]          divisor_q, divisor_d;
   div_op_t              op_q, op_d;
   logic [TAG_WIDTH-1:0] tag_q, tag_d;
   logic                 neg_a_q, neg_a_d;
   logic                 neg_b_q, neg_b_d;
   logic [31:0]          result_q, result_d;

   logic [31:0]          in_a;
   logic [31:0]          in_b;
   div_op_t              in_op;
   logic [63:0]          step_rq;
   logic                 accept;
   logic                 in_signed;
   logic [31:0]          fix_q;
   logic [31:0]          fix_r;

   assign in_a  = i_issue_data[RS1_DATA +: 32];
   assign in_b  = i_issue_data[RS2_DATA +: 32];
   assign in_op = div_op_t'(i_issue_data[DIV_OP +: 2]);

   // Operand valid bits and source tags are not needed here.
   logic unused_entry_bits;
   assign unused_entry_bits = ^{i_issue_data[DATA_WIDTH-1:DIV_OP+2],
                                i_issue_data[RS1_VLD:RS1_TAG],
                                i_issue_data[RS2_VLD:RS2_TAG]};

   exec_div_step u_step (
      .i_rq      (rq_q),
      .i_divisor (divisor_q),
      .o_rq      (step_rq)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rq_d      = rq_q;
      divisor_d = divisor_q;
      op_d      = op_q;
      tag_d     = tag_q;
      neg_a_d   = neg_a_q;
      neg_b_d   = neg_b_q;
      result_d  = result_q;
      fix_q     = 32'd0;
      fix_r     = 32'd0;
      in_signed = ~in_op[0];
      accept    = (state_q == IDLE) & i_issue_valid & ~i_flush & ~i_rst;

      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d      = in_op;
               tag_d     = i_issue_data[DEST_TAG +: TAG_WIDTH];
               neg_a_d   = in_signed & in_a[31];
               neg_b_d   = in_signed & in_b[31];
               rq_d      = {32'd0, (in_signed & in_a[31]) ? -in_a : in_a};
               divisor_d = (in_signed & in_b[31]) ? -in_b : in_b;
               cnt_d     = 6'd0;
               if (in_b == 32'd0) begin
                  result_d = in_op[1] ? in_a : 32'hFFFF_FFFF;
                  state_d  = DONE;
               end else if (in_signed && in_a == 32'h8000_0000 && in_b == 32'hFFFF_FFFF) begin
                  result_d = in_op[1] ? 32'd0 : 32'h8000_0000;
                  state_d  = DONE;
               end else begin
                  state_d  = DIV;
               end
            end
         end
         DIV: begin
            rq_d  = step_rq;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               // Quotient is negative when operand signs differ; the
               // remainder follows the dividend's sign.
               fix_q    = (neg_a_q ^ neg_b_q) ? -step_rq[31:0] : step_rq[31:0];
               fix_r    = neg_a_q ? -step_rq[63:32] : step_rq[63:32];
               result_d = op_q[1] ? fix_r : fix_q;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (i_cdb_grant) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (i_flush) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rq_q      <= '0;
         divisor_q <= '0;
         op_q      <= OP_DIV;
         tag_q     <= '0;
         neg_a_q   <= 1'b0;
         neg_b_q   <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rq_q      <= rq_d;
         divisor_q <= divisor_d;
         op_q      <= op_d;
         tag_q     <= tag_d;
         neg_a_q   <= neg_a_d;
         neg_b_q   <= neg_b_d;
         result_q  <= result_d;
      end
   end

   assign o_issue_completed = accept;
   assign o_busy            = (state_q != IDLE);
   assign o_cdb_req         = (state_q == DONE);
   // A flush or reset in the grant cycle suppresses the broadcast.
   assign o_cdb_valid       = (state_q == DONE) & i_cdb_grant & ~i_flush & ~i_rst;
   assign o_cdb_tag         = (state_q == DONE) ? tag_q : '0;
   assign o_cdb_data        = (state_q == DONE) ? result_q : 32'd0;

endmodule

// File: tb/tb_exec_div_unit.sv
module tb_exec_div_unit;

   localparam int DW = 128;

   logic          i_clk;
   logic          i_rst;
   logic          i_flush;
   logic          i_issue_valid;
   logic [DW-1:0] i_issue_data;
   logic          o_issue_completed;
   logic          o_busy;
   logic          o_cdb_req;
   logic          i_cdb_grant;
   logic          o_cdb_valid;
   logic [5:0]    o_cdb_tag;
   logic [31:0]   o_cdb_data;

   int errors = 0;
   int checks = 0;

   exec_div_unit #(.DATA_WIDTH(DW), .TAG_WIDTH(6)) dut (
      .i_clk             (i_clk),
      .i_rst             (i_rst),
      .i_flush           (i_flush),
      .i_issue_valid     (i_issue_valid),
      .i_issue_data      (i_issue_data),
      .o_issue_completed (o_issue_completed),
      .o_busy            (o_busy),
      .o_cdb_req         (o_cdb_req),
      .i_cdb_grant       (i_cdb_grant),
      .o_cdb_valid       (o_cdb_valid),
      .o_cdb_tag         (o_cdb_tag),
      .o_cdb_data        (o_cdb_data)
   );

   // ---------------- clock ----------------
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   function automatic logic [DW-1:0] make_entry(input logic [1:0] op, input logic [31:0] a,
                                                input logic [31:0] b, input logic [5:0] tag);
      logic [DW-1:0] e;
      e          = '0;
      e[83:52]   = a;
      e[51]      = 1'b1;
      e[44:13]   = b;
      e[12]      = 1'b1;
      e[5:0]     = tag;
      e[85:84]   = op;
      return e;
   endfunction

   // Driver: called 1 time unit after a rising edge. Presents the entry,
   // waits (bounded) for the request, grants immediately and returns one
   // unit after the edge that ends the grant cycle.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] tag, output logic acc, output int lat,
                         output logic [5:0] rtag, output logic [31:0] rdata, output logic rvalid);
      i_issue_data  = make_entry(op, a, b, tag);
      i_issue_valid = 1'b1;
      #1;
      acc = o_issue_completed;
      @(posedge i_clk); #1;
      i_issue_valid = 1'b0;
      i_issue_data  = '0;
      lat = 1;
      while (!o_cdb_req && lat < 200) begin
         @(posedge i_clk); #1;
         lat++;
      end
      rtag = o_cdb_tag;
      rdata = o_cdb_data;
      i_cdb_grant = 1'b1;
      #1;
      rvalid = o_cdb_valid;
      @(posedge i_clk); #1;
      i_cdb_grant = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      i_rst = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      #1;
      checks++;
      if ({o_busy, o_cdb_req, o_cdb_valid, o_issue_completed} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b want 0000", {o_busy, o_cdb_req, o_cdb_valid, o_issue_completed});
      end
      checks++;
      if ({o_cdb_tag, o_cdb_data} !== 38'd0) begin
         errors++;
         $display("FAIL reset_bus: tag=%h data=%h want 0", o_cdb_tag, o_cdb_data);
      end
   endtask

   task automatic test_divu();
      logic acc, rv; int lat; logic [5:0] t; logic [31:0] d;
      run_op(2'b01, 32'd100, 32'd7, 6'h2A, acc, lat, t, d, rv);
      checks++;
      if (acc !== 1'b1) begin errors++; $display("FAIL divu_accept: got %b want 1", acc); end
      checks++;
      if (lat != 33) begin errors++; $display("FAIL divu_latency: got %0d want 33", lat); end
      checks++;
      if (d !== 32'd14) begin errors++; $display("FAIL divu_data: got %h want 0000000e", d); end
      checks++;
      if (t !== 6'h2A) begin errors++; $display("FAIL divu_tag: got %h want 2a", t); end
      checks++;
      if (rv !== 1'b1) begin errors++; $display("FAIL divu_valid: got %b want 1", rv); end
      checks++;
      if (o_busy !== 1'b0) begin errors++; $display("FAIL divu_idle_after: busy=%b want 0", o_busy); end
   endtask

   task automatic test_signed();
      logic acc, rv; int lat; logic [5:0] t; logic [31:0] d;
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 6'h01, acc, lat, t, d, rv);
      checks++;
      if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_m7_2: got %h want ffffffff", d); end
      run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 6'h02, acc, lat, t, d, rv);
      checks++;
      if (d !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2: got %h want fffffffd", d); end
      checks++;
      if (lat != 33) begin errors++; $display("FAIL div_m7_2_latency: got %0d want 33", lat); end
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 6'h03, acc, lat, t, d, rv);
      checks++;
      if (d !== 32'd1) begin errors++; $display("FAIL remu_fff9_2: got %h want 00000001", d); end
      run_op(2'b00, 32'd100, 32'hFFFF_FFF9, 6'h04, acc, lat, t, d, rv);
      checks++;
      if (d !== 32'hFFFF_FFF2) begin errors++; $display("FAIL div_100_m7: got %h want fffffff2", d); end
      run_op(2'b10, 32'd100, 32'hFFFF_FFF9, 6'h05, acc, lat, t, d, rv);
      checks++;
      if (d !== 32'd2) begin errors++; $display("FAIL rem_100_m7: got %h want 00000002", d); end
      run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 6'h06, acc, lat, t, d, rv);
      checks++;
      if (d !== 32'd1) begin errors++; $display("FAIL remu_big: got %h want 00000001", d); end
   endtask

   task automatic test_special();
      logic acc, rv; int lat; logic [5:0] t; logic [31:0] d;
      run_op(2'b00, 32'd5, 32'd0, 6'h10, acc, lat, t, d, rv);
      checks++;
      if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_by0_data: got %h want ffffffff", d); end
      checks++;
      if (lat != 1) begin errors++; $display("FAIL div_by0_latency: got %0d want 1", lat); end
      run_op(2'b10, 32'd5, 32'd0, 6'h11, acc, lat, t, d, rv);
      checks++;
      if (d !== 32'd5) begin errors++; $display("FAIL rem_by0_data: got %h want 00000005", d); end
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 6'h12, acc, lat, t, d, rv);
      checks++;
      if (d !== 32'h8000_0000 || lat != 1) begin
         errors++; $display("FAIL div_ovf: data=%h lat=%0d want 80000000 lat 1", d, lat);
      end
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 6'h13, acc, lat, t, d, rv);
      checks++;
      if (d !== 32'd0 || t !== 6'h13) begin
         errors++; $display("FAIL rem_ovf: data=%h tag=%h want 0 tag 13", d, t);
      end
   endtask

   task automatic test_grant_stall();
      logic acc, rv; int lat; logic [5:0] t; logic [31:0] d;
      i_issue_data  = make_entry(2'b01, 32'd1000, 32'd3, 6'h21);
      i_issue_valid = 1'b1;
      @(posedge i_clk); #1;
      // Keep presenting another entry while the first one is in flight.
      i_issue_data = make_entry(2'b01, 32'd77, 32'd11, 6'h22);
      lat = 1;
      while (!o_cdb_req && lat < 200) begin
         @(posedge i_clk); #1;
         lat++;
      end
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (o_cdb_req !== 1'b1 || o_cdb_tag !== 6'h21 || o_cdb_data !== 32'd333 ||
             o_cdb_valid !== 1'b0 || o_issue_completed !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold%0d: req=%b tag=%h data=%h valid=%b acc=%b want 1 21 0000014d 0 0",
                     i, o_cdb_req, o_cdb_tag, o_cdb_data, o_cdb_valid, o_issue_completed);
         end
         @(posedge i_clk); #1;
      end
      i_cdb_grant = 1'b1;
      #1;
      checks++;
      if (o_cdb_valid !== 1'b1 || o_issue_completed !== 1'b0) begin
         errors++;
         $display("FAIL stall_grant: valid=%b acc=%b want 1 0", o_cdb_valid, o_issue_completed);
      end
      @(posedge i_clk); #1;
      i_cdb_grant = 1'b0;
      #1;
      checks++;
      if (o_issue_completed !== 1'b1 || o_cdb_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_next_accept: acc=%b valid=%b want 1 0", o_issue_completed, o_cdb_valid);
      end
      @(posedge i_clk); #1;
      i_issue_valid = 1'b0;
      i_issue_data  = '0;
      lat = 1;
      while (!o_cdb_req && lat < 200) begin
         @(posedge i_clk); #1;
         lat++;
      end
      t = o_cdb_tag;
      d = o_cdb_data;
      i_cdb_grant = 1'b1;
      @(posedge i_clk); #1;
      i_cdb_grant = 1'b0;
      checks++;
      if (d !== 32'd7 || t !== 6'h22 || lat != 33) begin
         errors++; $display("FAIL stall_second_op: data=%h tag=%h lat=%0d want 7 22 33", d, t, lat);
      end
      acc = 1'b0; rv = 1'b0;
   endtask

   task automatic test_flush();
      logic acc, rv; int lat; logic [5:0] t; logic [31:0] d;
      logic seen;
      i_issue_data  = make_entry(2'b01, 32'd500, 32'd5, 6'h30);
      i_issue_valid = 1'b1;
      @(posedge i_clk); #1;
      i_issue_valid = 1'b0;
      repeat (9) @(posedge i_clk);
      #1;
      // Now in cycle 10 of the operation.
      i_flush = 1'b1;
      i_cdb_grant = 1'b1;
      #1;
      checks++;
      if (o_cdb_valid !== 1'b0 || o_busy !== 1'b1) begin
         errors++; $display("FAIL flush_cycle: valid=%b busy=%b want 0 1", o_cdb_valid, o_busy);
      end
      @(posedge i_clk); #1;
      i_flush = 1'b0;
      i_cdb_grant = 1'b0;
      #1;
      checks++;
      if (o_busy !== 1'b0 || o_cdb_req !== 1'b0) begin
         errors++; $display("FAIL flush_idle: busy=%b req=%b want 0 0", o_busy, o_cdb_req);
      end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge i_clk); #1;
         if (o_cdb_req || o_cdb_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_req: got %b want 0", seen); end
      run_op(2'b00, 32'd1000, 32'd10, 6'h31, acc, lat, t, d, rv);
      checks++;
      if (acc !== 1'b1 || d !== 32'd100 || t !== 6'h31 || rv !== 1'b1) begin
         errors++; $display("FAIL flush_after_op: acc=%b data=%h tag=%h valid=%b want 1 64 31 1", acc, d, t, rv);
      end
   endtask

   task automatic test_reset_done();
      i_issue_data  = make_entry(2'b00, 32'd5, 32'd0, 6'h3F);
      i_issue_valid = 1'b1;
      @(posedge i_clk); #1;
      i_issue_valid = 1'b0;
      i_issue_data  = '0;
      checks++;
      if (o_cdb_req !== 1'b1) begin errors++; $display("FAIL rstdone_req: got %b want 1", o_cdb_req); end
      i_cdb_grant = 1'b1;
      i_rst = 1'b1;
      #1;
      checks++;
      if (o_cdb_valid !== 1'b0) begin errors++; $display("FAIL rstdone_valid: got %b want 0", o_cdb_valid); end
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      i_cdb_grant = 1'b0;
      #1;
      checks++;
      if ({o_busy, o_cdb_req, o_cdb_valid, o_issue_completed, o_cdb_tag, o_cdb_data} !== 42'd0) begin
         errors++;
         $display("FAIL rstdone_outputs: busy=%b req=%b valid=%b acc=%b tag=%h data=%h want all 0",
                  o_busy, o_cdb_req, o_cdb_valid, o_issue_completed, o_cdb_tag, o_cdb_data);
      end
   endtask

   task automatic test_back_to_back();
      logic acc, rv; int lat; logic [5:0] t; logic [31:0] d;
      run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 6'h0A, acc, lat, t, d, rv);
      checks++;
      if (d !== 32'hFFFF_FFFF || lat != 33) begin
         errors++; $display("FAIL b2b_first: data=%h lat=%0d want ffffffff 33", d, lat);
      end
      run_op(2'b01, 32'd81, 32'd9, 6'h0B, acc, lat, t, d, rv);
      checks++;
      if (acc !== 1'b1 || d !== 32'd9 || t !== 6'h0B || lat != 33) begin
         errors++; $display("FAIL b2b_second: acc=%b data=%h tag=%h lat=%0d want 1 9 0b 33", acc, d, t, lat);
      end
   endtask

   initial begin
      i_rst         = 1'b1;
      i_flush       = 1'b0;
      i_issue_valid = 1'b0;
      i_issue_data  = '0;
      i_cdb_grant   = 1'b0;
      test_reset();
      test_divu();
      test_signed();
      test_special();
      test_grant_stall();
      test_flush();
      test_reset_done();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
